// File: rtl/gpio_input_filter_if.sv
// rtl/gpio_input_filter_if.sv - pad/interrupt bundle between pad ring, input filter and core
//
// Purpose: groups the per-pin signals of the GPIO input filter.
// Signals (all WIDTH bits unless noted):
//   pad_in    raw pad levels, asynchronous to the filter clock
//   rise_ie   per-pin rising-edge interrupt enable
//   fall_ie   per-pin falling-edge interrupt enable
//   pend_clr  per-pin one-cycle clear of both pending flags
//   gpio_in   synchronized, debounced pin levels
//   rise_pend sticky rising-edge flags
//   fall_pend sticky falling-edge flags
//   irq       (1 bit) any enabled pending flag
// Modports: master = core/pad side, slave = the filter.

interface gpio_input_filter_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] rise_ie;
   logic [WIDTH-1:0] fall_ie;
   logic [WIDTH-1:0] pend_clr;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] rise_pend;
   logic [WIDTH-1:0] fall_pend;
   logic             irq;

   modport master (
      output pad_in, rise_ie, fall_ie, pend_clr,
      input  gpio_in, rise_pend, fall_pend, irq
   );

   modport slave (
      input  pad_in, rise_ie, fall_ie, pend_clr,
      output gpio_in, rise_pend, fall_pend, irq
   );
endinterface

// File: rtl/gpio_input_filter.sv
// rtl/gpio_input_filter.sv - per-pin synchronizer, debouncer and edge-pending flags
//
// Purpose: each pad bit is brought into the clk domain through two flops, then
// accepted as a new level only after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with the current accepted level. Accepted level changes set
// sticky rise/fall pending flags; irq is the OR of enabled pending flags.
// Ports:
//   clk   single clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   gpio_input_filter_if.slave (pad_in, rise_ie, fall_ie, pend_clr in;
//         gpio_in, rise_pend, fall_pend, irq out)

module gpio_input_filter #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rstn,
   gpio_input_filter_if.slave bus
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic [WIDTH-1:0]          sync1_q, sync1_d;
   logic [WIDTH-1:0]          sync2_q, sync2_d;
   logic [WIDTH-1:0]          stable_q, stable_d;
   logic [WIDTH-1:0]          rise_pend_q, rise_pend_d;
   logic [WIDTH-1:0]          fall_pend_q, fall_pend_d;
   logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;

   always_comb begin
      // Plain two-flop chain: nothing sits between sync1 and sync2.
      sync1_d  = bus.pad_in;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;

      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            // Any agreeing sample throws away a partial disagreement run.
            cnt_d[i] = '0;
         end else if (cnt_q[i] >= CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th disagreeing sample: accept it.
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end

      // A new edge wins over a coincident clear so no event is lost.
      rise_pend_d = (rise_pend_q & ~bus.pend_clr) | (stable_d & ~stable_q);
      fall_pend_d = (fall_pend_q & ~bus.pend_clr) | (~stable_d & stable_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         cnt_q       <= '0;
         rise_pend_q <= '0;
         fall_pend_q <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         cnt_q       <= cnt_d;
         rise_pend_q <= rise_pend_d;
         fall_pend_q <= fall_pend_d;
      end
   end

   assign bus.gpio_in   = stable_q;
   assign bus.rise_pend = rise_pend_q;
   assign bus.fall_pend = fall_pend_q;
   // Only registered flags feed irq, so pads never reach it combinationally.
   assign bus.irq       = |((rise_pend_q & bus.rise_ie) | (fall_pend_q & bus.fall_ie));

endmodule

// File: doc/gpio_input_filter.md
GPIO_INPUT_FILTER -- requirements
Module: gpio_input_filter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: number of GPIO pins.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required before accepting a change; legal range 1..65535; 1 = no filtering.
REQ-003 SHALL have port clk  input  1: single clock; all state on its rising edge.
REQ-004 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port pad_in  input  WIDTH: raw pad levels, asynchronous to clk.
REQ-006 SHALL have port gpio_in  output  WIDTH: synchronized, debounced pin levels fed to the core's GPIO input.
REQ-007 SHALL have port rise_ie  input  WIDTH: per-pin rising-edge interrupt enable.
REQ-008 SHALL have port fall_ie  input  WIDTH: per-pin falling-edge interrupt enable.
REQ-009 SHALL have port pend_clr  input  WIDTH: per-pin one-cycle clear of both pending flags.
REQ-010 SHALL have port rise_pend  output  WIDTH: sticky rising-edge flags.
REQ-011 SHALL have port fall_pend  output  WIDTH: sticky falling-edge flags.
REQ-012 SHALL have port irq  output  1: OR of (rise_pend & rise_ie) | (fall_pend & fall_ie) over all pins.

Function
REQ-013 SHALL pass each pad_in bit through a 2-flop synchronizer (sync1, sync2); no logic between the two flops.
REQ-014 SHALL keep per pin a stable register (drives gpio_in) and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-015 SHALL reset a pin's counter to 0 on every cycle where sync2 equals stable.
REQ-016 SHALL increment the counter on every cycle where sync2 differs from stable and counter < DEBOUNCE_CYCLES-1.
REQ-017 SHALL, when sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, load stable <= sync2 and counter <= 0 on that edge.
REQ-018 SHALL, for a pad change captured by sync1 at edge k and held, update gpio_in at edge k+DEBOUNCE_CYCLES+1.
REQ-019 SHALL discard any disagreement shorter than DEBOUNCE_CYCLES consecutive sync2 samples; gpio_in and pending flags stay unchanged.
REQ-020 SHALL set rise_pend[i] on the same edge that stable[i] goes 0->1, and fall_pend[i] on the same edge that stable[i] goes 1->0.
REQ-021 SHALL clear rise_pend[i] and fall_pend[i] on the edge after pend_clr[i] is sampled high.
REQ-022 SHALL give set priority over clear when a set and pend_clr[i] coincide on the same edge: the flag ends at 1.
REQ-023 SHALL keep pending flags set regardless of rise_ie/fall_ie; enables gate only irq.
REQ-024 SHALL compute irq combinationally from the pending registers and enable inputs, with no pad-to-irq combinational path.
REQ-025 SHALL process every pin independently; simultaneous events on several pins neither interact nor are lost.
REQ-026 SHALL saturate the counter at DEBOUNCE_CYCLES-1; the counter never wraps.

Reset
REQ-027 SHALL, while rstn is low, force sync1, sync2, stable, counters, rise_pend and fall_pend to 0 immediately, independent of clk.
REQ-028 SHALL drive gpio_in=0, rise_pend=0, fall_pend=0 and irq=0 during reset.
REQ-029 SHALL abandon any in-progress debounce count on reset; no partial count survives.
REQ-030 SHALL, after reset release with a pad held high, treat the pin as a 0->1 change: gpio_in goes 1 and rise_pend is set per REQ-018/REQ-020.

Verification (DEBOUNCE_CYCLES=4, WIDTH=16)
REQ-031 SHALL cover: pad_in[0] 0->1 captured at edge k, held, rise_ie[0]=1 -> gpio_in[0]=1 and rise_pend[0]=1 at edge k+5, irq=1 in the same cycle.
REQ-032 SHALL cover: pad_in[1] high for 3 cycles then low -> gpio_in[1] stays 0, rise_pend[1] and fall_pend[1] stay 0, irq stays 0.
REQ-033 SHALL cover: rise_pend[0]=1, pend_clr[0] pulsed -> rise_pend[0]=0 next edge and irq drops; repeat with pend_clr[2] on the same edge as pin 2's stable change -> rise_pend[2] stays 1.
REQ-034 SHALL cover: pin 3 falls with fall_ie[3]=0 -> fall_pend[3]=1, irq=0; fall_ie[3] raised -> irq=1 in the same cycle.
REQ-035 SHALL cover: rstn low for 1 cycle two cycles into a pin 4 count -> all outputs 0 at once; pad held high after release -> gpio_in[4]=1 and rise_pend[4]=1 exactly 5 edges after first sync1 capture.
REQ-036 SHALL cover: pad_in 0x0000->0xFFFF in one cycle -> gpio_in=0xFFFF and rise_pend=0xFFFF on the same edge; then 0xFFFF->0xA5A5 -> fall_pend=0x5A5A.
